// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, depth and FSM state type for the register-file reader
package regfile_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } rdr_state_t;

endpackage

// File: rtl/regfile_reader.sv
// rtl/regfile_reader.sv - streams a register-file address range out on a valid/ready port (optional REGFILE_READER_CHECKSUM_EN)
module regfile_reader #(
  parameter int ADDR_W = regfile_pkg::RF_ADDR_W,
  parameter int DATA_W = regfile_pkg::RF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] RA,
  input  logic [DATA_W-1:0] RD,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  import regfile_pkg::*;

  rdr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last_q;
  logic              accept;
  logic              handshake;
  logic              at_last;

  assign accept    = (state == IDLE) && start;
  assign handshake = (state == SEND) && out_valid && out_ready;
  assign at_last   = (cnt == last_q);

  // The counter doubles as the read address, so RA naturally holds outside LOAD.
  assign RA   = cnt;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: if (handshake) state_nxt = at_last ? DONE : LOAD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address counter, latched range end and the output word register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      last_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= first;
            last_q <= last;
          end
        end
        LOAD: begin
          out_data  <= RD;
          out_addr  <= cnt;
          out_valid <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (!at_last) cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REGFILE_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Running XOR of every accepted word, cleared when a new dump starts
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            csum_q <= '0;
    else if (accept)    csum_q <= '0;
    else if (handshake) csum_q <= csum_q ^ out_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_reader.sv
// tb/tb_regfile_reader.sv - directed self-checking bench for regfile_reader
module tb_regfile_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first;
  logic [4:0]  last;
  logic [4:0]  RA;
  logic [31:0] RD;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] rf [32];

  logic [4:0]  cap_addr [64];
  logic [31:0] cap_data [64];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Register-file model: combinational read, write on the rising edge
  assign RD = rf[RA];
  always @(posedge clk) if (we) rf[wa] <= wd;

  regfile_reader dut (
    .CLK(clk), .RST(rst), .start(start), .first(first), .last(last),
    .RA(RA), .RD(RD), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done),
    .checksum(checksum)
  );

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1 we = 1'b0;
  endtask

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk); first = f; last = l; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Observes one negedge per cycle after the start edge (c=0 is the LOAD cycle).
  task automatic collect(input int pulse_at, input int stop_after, output int n, output int dcyc);
    n = 0;
    dcyc = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (done) begin
        dcyc = c;
        break;
      end
      if (out_valid && out_ready) begin
        if (n < 64) begin
          cap_addr[n] = out_addr;
          cap_data[n] = out_data;
        end
        n++;
        if (stop_after > 0 && n == stop_after) break;
      end
      if (c == pulse_at) begin
        start = 1'b1; first = 5'd20; last = 5'd25;
      end
    end
  endtask

  function automatic logic [31:0] full_xor();
    logic [31:0] x = '0;
    for (int i = 0; i < 32; i++) x = x ^ (32'h100 + i);
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || RA !== 5'd0 ||
        out_data !== 32'd0 || out_addr !== 5'd0 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b RA=%0d data=%h addr=%0d csum=%h required all zero",
               out_valid, busy, done, RA, out_data, out_addr, checksum);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) rf_write(5'(i), 32'h100 + i);
  endtask

  task automatic test_full_range();
    int n, d;
    logic [31:0] exp_csum;
    start_dump(5'd0, 5'd31);
    collect(-1, 0, n, d);
    checks++;
    if (n !== 32) begin errors++; $display("FAIL full_count: got %0d required 32", n); end
    checks++;
    if (d !== 64) begin errors++; $display("FAIL full_done_cycle: got %0d required 64", d); end
    for (int i = 0; i < 32 && i < n; i++) begin
      checks++;
      if (cap_addr[i] !== 5'(i) || cap_data[i] !== 32'h100 + i) begin
        errors++;
        $display("FAIL full_word[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                 i, cap_addr[i], cap_data[i], i, 32'h100 + i);
      end
    end
`ifdef REGFILE_READER_CHECKSUM_EN
    exp_csum = full_xor();
`else
    exp_csum = 32'd0;
`endif
    checks++;
    if (checksum !== exp_csum) begin
      errors++; $display("FAIL full_checksum: got %h required %h", checksum, exp_csum);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL full_busy_clear: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (RA !== 5'd31) begin errors++; $display("FAIL full_ra_hold: got %0d required 31", RA); end
  endtask

  task automatic test_wrap();
    int n, d;
    logic [4:0] exp_a [4];
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
    start_dump(5'd30, 5'd1);
    collect(-1, 0, n, d);
    checks++;
    if (n !== 4 || d < 0) begin errors++; $display("FAIL wrap_count: got %0d done_cycle %0d required 4 words and done", n, d); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (cap_addr[i] !== exp_a[i] || cap_data[i] !== 32'h100 + 32'(exp_a[i])) begin
        errors++;
        $display("FAIL wrap_word[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                 i, cap_addr[i], cap_data[i], exp_a[i], 32'h100 + 32'(exp_a[i]));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int waited;
    logic [31:0] exp_csum;
    out_ready = 1'b0;
    start_dump(5'd7, 5'd7);
    waited = 0;
    while (!out_valid && waited < 10) begin @(negedge clk); waited++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: valid=%b required 1", out_valid); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h107 || out_addr !== 5'd7) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h addr=%0d required 1 00000107 7", k, out_valid, out_data, out_addr);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL bp_done: valid=%b done=%b required 0 1", out_valid, done);
    end
`ifdef REGFILE_READER_CHECKSUM_EN
    exp_csum = 32'h107;
`else
    exp_csum = 32'd0;
`endif
    checks++;
    if (checksum !== exp_csum) begin errors++; $display("FAIL bp_checksum: got %h required %h", checksum, exp_csum); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_start_ignored();
    int n, d;
    start_dump(5'd0, 5'd3);
    collect(1, 0, n, d);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL ignore_count: got %0d required 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (cap_addr[i] !== 5'(i)) begin
        errors++; $display("FAIL ignore_addr[%0d]: got %0d required %0d", i, cap_addr[i], i);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b required 0", busy); end
  endtask

  task automatic test_write_collision();
    int n, d;
    start_dump(5'd4, 5'd4);
    rf_write(5'd4, 32'hDEAD_BEEF);
    collect(-1, 0, n, d);
    checks++;
    if (n !== 1 || cap_data[0] !== 32'h104) begin
      errors++; $display("FAIL collide_old: words=%0d data=%h required 1 00000104", n, cap_data[0]);
    end
    @(negedge clk);
    start_dump(5'd4, 5'd4);
    collect(-1, 0, n, d);
    checks++;
    if (n !== 1 || cap_data[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL collide_new: words=%0d data=%h required 1 deadbeef", n, cap_data[0]);
    end
    @(negedge clk);
    rf_write(5'd4, 32'h104);
  endtask

  task automatic test_reset_mid();
    int n, d;
    start_dump(5'd0, 5'd31);
    collect(-1, 3, n, d);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || RA !== 5'd0 ||
        out_data !== 32'd0 || out_addr !== 5'd0 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL midreset_zero: valid=%b busy=%b done=%b RA=%0d data=%h addr=%0d csum=%h required all zero",
               out_valid, busy, done, RA, out_data, out_addr, checksum);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midreset_nodone[%0d]: done=%b busy=%b required 0 0", k, done, busy);
      end
    end
    rst = 1'b0;
    start_dump(5'd0, 5'd31);
    collect(-1, 0, n, d);
    checks++;
    if (n !== 32 || d !== 64) begin
      errors++; $display("FAIL midreset_redump: words=%0d done_cycle=%0d required 32 64", n, d);
    end
    for (int i = 0; i < 32 && i < n; i++) begin
      checks++;
      if (cap_addr[i] !== 5'(i) || cap_data[i] !== 32'h100 + i) begin
        errors++;
        $display("FAIL redump_word[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                 i, cap_addr[i], cap_data[i], i, 32'h100 + i);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; first = '0; last = '0;
    out_ready = 1'b1; we = 1'b0; wa = '0; wd = '0;
    test_reset();
    test_full_range();
    test_wrap();
    test_backpressure();
    test_start_ignored();
    test_write_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Read-side streaming engine for the 32 x 32 register file. On a start pulse it walks a programmed address range through one register-file read port and emits each word, tagged with its address, on a valid/ready output stream with full backpressure. It sits beside the ALU write-back datapath and gives the bench, debug logic or a downstream consumer an ordered dump of register state. The ALU write port can keep running while the dump proceeds.

## Interface
- `ADDR_W`, 5: register-file address width.
- `DATA_W`, 32: register word width.

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `first`  in  ADDR_W  first address of the range; latched on an accepted start.
- `last`  in  ADDR_W  last address of the range, inclusive; latched on an accepted start.
- `RA`  out  ADDR_W  read address, wired to the register-file read-address port (A1/A2 side).
- `RD`  in  DATA_W  read data from the register file (combinational read of `RA`).
- `out_valid`  out  1  `out_data`/`out_addr` hold a word.
- `out_ready`  in  1  consumer accepts the word when high together with `out_valid`.
- `out_data`  out  DATA_W  captured register word.
- `out_addr`  out  ADDR_W  address the word was read from.
- `busy`  out  1  high from the accepted start until the cycle after `done`.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `checksum`  out  DATA_W  XOR of all words in the stream (see Configuration).

## Operation
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - On `start`=1, latch `first` and `last`, set the address counter to `first`, set `busy`=1, and go to LOAD.
- LOAD:
  - Drive `RA` with the counter value.
  - At the edge, capture `RD` into `out_data` and the counter into `out_addr`, set `out_valid`=1, and go to SEND.
- SEND:
  - Hold `out_valid`, `out_data` and `out_addr` stable until `out_valid && out_ready`.
  - On that handshake, clear `out_valid`.
  - If counter == latched `last`, go to DONE.
  - Otherwise increment the counter modulo 2^ADDR_W and go to LOAD.
- DONE:
  - Assert `done` for one cycle, clear `busy` at the following edge, and return to IDLE.
- Word count is ((last − first) mod 32) + 1.
  - `first` == `last` gives exactly one word.
  - `last` < `first` wraps: for example, 30..1 streams 30, 31, 0, 1.
  - The maximum range is 32 words (for example `first`=5, `last`=4).
- `start` outside IDLE is ignored. `first`/`last` changes after an accepted start have no effect.
- Concurrent register-file write to the address being read in LOAD: the captured word is the pre-write contents, i.e. the value present before that edge.
- `RA` holds its last value in IDLE, SEND and DONE.
- Reset values (immediate on `RST`, also mid-dump): state IDLE, `RA`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `busy`=0, `done`=0, `checksum`=0, counter=0.
  - A partially sent dump is abandoned with no `done`.

## Timing
- `start` sampled at edge k → LOAD during cycle k→k+1 → `out_valid` high after edge k+1.
- Handshake at edge n, more words remaining → LOAD in cycle n→n+1 → next `out_valid` after edge n+1.
  - Peak throughput is one word per 2 cycles with `out_ready` tied high.
- Handshake on the last word at edge n → `done`=1 during cycle n→n+1 → `busy`=0 after edge n+1.
- A new `start` is accepted from cycle n+2 onward.
- A 32-word dump with `out_ready`=1 takes 65 cycles from start edge to `done` deassertion.

## Configuration
- Macro: `REGFILE_READER_CHECKSUM_EN`.
- Defined:
  - `checksum` is cleared on an accepted start.
  - On each handshake it updates to `checksum ^ out_data`.
  - It is stable and valid while `done`=1 and holds until the next start.
- Undefined: `checksum` is tied to 0 and no accumulator register is generated.

## Structure
- Shared package `regfile_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - FSM state enum `rdr_state_t` (IDLE, LOAD, SEND, DONE).
  - Constant `RF_DEPTH` = 32.
- No sub-module required. The register file is external; the top level connects `RA`→A1 and RD1→`RD` alongside the existing datapath.

## Test plan
- Preload r0..r31 = 32'h100+i, `first`=0, `last`=31, `out_ready`=1 → 32 words, `out_addr` 0..31, `out_data` 0x100..0x11F, `done` at cycle 64 after the start edge; checksum = XOR of those values.
- `first`=30, `last`=1 → words from addresses 30, 31, 0, 1 in order, then `done`.
- `first`=`last`=7, `out_ready` held low 5 cycles → `out_valid` stays high with data/addr stable for all 5 cycles; one transfer, then `done`.
- Second `start` pulse during SEND → ignored; word count unchanged.
- Write 32'hDEAD_BEEF to r4 on the same edge as LOAD of address 4 → old r4 value streamed; the next dump returns 32'hDEAD_BEEF.
- Assert `RST` mid-dump (after 3 words) → all outputs 0 immediately, no `done`; a new start dumps the full range correctly.
